capcnt_bank: RTL and testbench

Parametrised bank of N_CH tick counters with per-channel capture source, delta/absolute mode, sequence numbering, overrun detection and interrupt. It generalises the fixed E1 tick/PPS capture counters in the misc peripheral into one Wishbone slave. Typical inputs are E1 RX/TX ticks, captured on USB SOF or GPS PPS. It sits on the same Wishbone bus as the other misc peripherals.

---
 rtl/capcnt_bank_pkg.sv | 24 ++
 rtl/capcnt_bank_ch.sv | 59 +++++
 rtl/capcnt_bank.sv | 88 ++++++++
 tb/tb_capcnt_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/capcnt_bank_pkg.sv
// capcnt_bank_pkg: register map, STAT layout and address helpers for capcnt_bank
package capcnt_bank_pkg;
  localparam logic [7:0] ADDR_EN = 8'h00;
  localparam logic [7:0] ADDR_SRC = 8'h01;
  localparam logic [7:0] ADDR_MODE = 8'h02;
  localparam logic [7:0] ADDR_IRQ_EN = 8'h03;
  localparam logic [7:0] ADDR_CAP_BASE = 8'h10;
  localparam logic [7:0] ADDR_STAT_BASE = 8'h11;
  localparam int STAT_VALID = 31;
  localparam int STAT_OVERRUN = 30;
  localparam int STAT_WRAP = 29;
  function automatic logic [7:0] cap_addr(input int c);
    return ADDR_CAP_BASE + 8'(2 * c);
  endfunction
  function automatic logic [7:0] stat_addr(input int c);
    return ADDR_STAT_BASE + 8'(2 * c);
  endfunction
  function automatic logic [31:0] stat_word(input logic v, input logic o, input logic w, input logic [15:0] seq);
    stat_word = 32'(seq);
    stat_word[STAT_VALID] = v;
    stat_word[STAT_OVERRUN] = o;
    stat_word[STAT_WRAP] = w;
  endfunction
endpackage

// File: rtl/capcnt_bank_ch.sv
// capcnt_bank_ch: one tick counter with capture, wrap, valid/overrun flags and sequence number
module capcnt_bank_ch #(
  parameter int W = 16,
  parameter int SEQ_W = 16
) (
  input logic clk,
  input logic rst,
  input logic inc,
  input logic cap,
  input logic mode,
  input logic en,
  input logic rd_clr,
  output logic [W-1:0] cap_val,
  output logic valid,
  output logic overrun,
  output logic wrap_st,
  output logic [SEQ_W-1:0] seq
);
  logic [W-1:0] cnt_q, cnt_d, cap_q, cap_d;
  logic wrap_q, wrap_d, valid_q, valid_d, ovr_q, ovr_d, wst_q, wst_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic take, roll, v_kept;
  always_comb begin
    take = en & cap;
    roll = inc & (&cnt_q);
    v_kept = valid_q & ~rd_clr;
    cnt_d = !en ? '0 : (take & ~mode) ? W'(inc) : cnt_q + W'(inc);
    wrap_d = en & (take ? (mode & roll) : (wrap_q | roll));
    cap_d = take ? cnt_q : cap_q;
    valid_d = take | v_kept;
    ovr_d = (ovr_q & ~rd_clr) | (take & v_kept);
    wst_d = take ? wrap_q : (wst_q & ~rd_clr);
    seq_d = seq_q + SEQ_W'(take);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cap_q <= '0;
      wrap_q <= 1'b0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      wst_q <= 1'b0;
      seq_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      wrap_q <= wrap_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      wst_q <= wst_d;
      seq_q <= seq_d;
    end
  end
  assign cap_val = cap_q;
  assign valid = valid_q;
  assign overrun = ovr_q;
  assign wrap_st = wst_q;
  assign seq = seq_q;
endmodule

// File: rtl/capcnt_bank.sv
// capcnt_bank: Wishbone bank of capture tick counters with source mux, read mux and irq
module capcnt_bank
  import capcnt_bank_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 16,
  parameter int SEQ_W = 16
) (
  input logic clk,
  input logic rst,
  input logic [N_CH-1:0] inc,
  input logic cap_sof,
  input logic cap_pps,
  output logic irq,
  input logic [7:0] wb_addr,
  output logic [31:0] wb_rdata,
  input logic [31:0] wb_wdata,
  input logic wb_we,
  input logic wb_cyc,
  output logic wb_ack
);
  logic [N_CH-1:0] en_q, en_d, src_q, src_d, mode_q, mode_d, ie_q, ie_d;
  logic ack_q, ack_d, irq_q, irq_d, wr, rd;
  logic [N_CH-1:0] cap, rd_clr, valid, overrun, wrap_st;
  logic [W-1:0] cap_val [N_CH];
  logic [SEQ_W-1:0] seq [N_CH];
  logic [31:0] rd_data;
  logic unused_wdata;
  assign unused_wdata = ^wb_wdata[31:N_CH];
  always_comb begin
    wr = ack_q & wb_cyc & wb_we;
    rd = ack_q & wb_cyc & ~wb_we;
    en_d = (wr && wb_addr == ADDR_EN) ? wb_wdata[N_CH-1:0] : en_q;
    src_d = (wr && wb_addr == ADDR_SRC) ? wb_wdata[N_CH-1:0] : src_q;
    mode_d = (wr && wb_addr == ADDR_MODE) ? wb_wdata[N_CH-1:0] : mode_q;
    ie_d = (wr && wb_addr == ADDR_IRQ_EN) ? wb_wdata[N_CH-1:0] : ie_q;
    ack_d = wb_cyc & ~ack_q;
    irq_d = |(valid & ie_q & en_q);
  end
  always_comb begin
    rd_data = wb_addr == ADDR_EN ? 32'(en_q) :
              wb_addr == ADDR_SRC ? 32'(src_q) :
              wb_addr == ADDR_MODE ? 32'(mode_q) :
              wb_addr == ADDR_IRQ_EN ? 32'(ie_q) : '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wb_addr == cap_addr(c)) rd_data = 32'(cap_val[c]);
      if (wb_addr == stat_addr(c)) rd_data = stat_word(valid[c], overrun[c], wrap_st[c], 16'(seq[c]));
    end
    wb_rdata = ack_q ? rd_data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
      src_q <= '0;
      mode_q <= '0;
      ie_q <= '0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      en_q <= en_d;
      src_q <= src_d;
      mode_q <= mode_d;
      ie_q <= ie_d;
      ack_q <= ack_d;
      irq_q <= irq_d;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign cap[i] = src_q[i] ? cap_pps : cap_sof;
    assign rd_clr[i] = rd && wb_addr == stat_addr(i);
    capcnt_bank_ch #(.W(W), .SEQ_W(SEQ_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .inc(inc[i]),
      .cap(cap[i]),
      .mode(mode_q[i]),
      .en(en_q[i]),
      .rd_clr(rd_clr[i]),
      .cap_val(cap_val[i]),
      .valid(valid[i]),
      .overrun(overrun[i]),
      .wrap_st(wrap_st[i]),
      .seq(seq[i])
    );
  end
  assign wb_ack = ack_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_capcnt_bank.sv
// tb_capcnt_bank: directed test of a W=16 and a W=8 bank sharing one stimulus, against a behavioural model
module tb_capcnt_bank;
  logic clk, rst, cap_sof, cap_pps, wb_we, wb_cyc;
  logic [3:0] inc;
  logic [7:0] wb_addr;
  logic [31:0] wb_wdata, rdata16, rdata8, d16, d8;
  logic irq16, irq8, ack16, ack8;
  int n_pass, n_total;

  capcnt_bank #(.N_CH(4), .W(16), .SEQ_W(16)) u16 (
    .clk(clk), .rst(rst), .inc(inc), .cap_sof(cap_sof), .cap_pps(cap_pps), .irq(irq16),
    .wb_addr(wb_addr), .wb_rdata(rdata16), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack16)
  );
  capcnt_bank #(.N_CH(4), .W(8), .SEQ_W(8)) u8 (
    .clk(clk), .rst(rst), .inc(inc), .cap_sof(cap_sof), .cap_pps(cap_pps), .irq(irq8),
    .wb_addr(wb_addr), .wb_rdata(rdata8), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(ack8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int wk[2] = '{16, 8};
  int sk[2] = '{16, 8};
  longint tot[2][4], base[2][4], mcap[2][4];
  int mseq[2][4];
  bit [3:0] mv[2], mo[2], mw[2];
  bit [3:0] m_en, m_src, m_mode, m_ie;
  bit m_ack;
  bit m_irq[2];
  bit clr, capt, v, o, w;
  longint mm;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          tot[k][c] = 0; base[k][c] = 0; mcap[k][c] = 0; mseq[k][c] = 0;
        end
        mv[k] = 0; mo[k] = 0; mw[k] = 0; m_irq[k] = 0;
      end
      m_en = 0; m_src = 0; m_mode = 0; m_ie = 0; m_ack = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_irq[k] = |(mv[k] & m_ie & m_en);
        mm = longint'(1) << wk[k];
        for (int c = 0; c < 4; c++) begin
          clr = m_ack && wb_cyc && !wb_we && wb_addr == 8'(17 + 2 * c);
          capt = m_en[c] && (m_src[c] ? cap_pps : cap_sof);
          v = mv[k][c] && !clr;
          o = mo[k][c] && !clr;
          w = mw[k][c] && !clr;
          if (!m_en[c]) begin
            tot[k][c] = 0;
            base[k][c] = 0;
          end else if (capt) begin
            mcap[k][c] = tot[k][c] % mm;
            w = (tot[k][c] / mm) != (base[k][c] / mm);
            o = o || v;
            v = 1;
            mseq[k][c] = (mseq[k][c] + 1) % (1 << sk[k]);
            if (m_mode[c]) begin
              base[k][c] = tot[k][c];
              tot[k][c] = tot[k][c] + longint'(inc[c]);
            end else begin
              base[k][c] = 0;
              tot[k][c] = longint'(inc[c]);
            end
          end else tot[k][c] = tot[k][c] + longint'(inc[c]);
          mv[k][c] = v; mo[k][c] = o; mw[k][c] = w;
        end
      end
      if (m_ack && wb_cyc && wb_we) begin
        if (wb_addr == 8'h00) m_en = wb_wdata[3:0];
        if (wb_addr == 8'h01) m_src = wb_wdata[3:0];
        if (wb_addr == 8'h02) m_mode = wb_wdata[3:0];
        if (wb_addr == 8'h03) m_ie = wb_wdata[3:0];
      end
      m_ack = wb_cyc && !m_ack;
    end
  end

  function automatic logic [31:0] exp_rd(input int k);
    int a = int'(wb_addr);
    int c = (a - 16) / 2;
    if (!m_ack) return 0;
    if (a == 0) return 32'(m_en);
    if (a == 1) return 32'(m_src);
    if (a == 2) return 32'(m_mode);
    if (a == 3) return 32'(m_ie);
    if (a >= 16 && a < 24) return (a % 2 == 1) ? {mv[k][c], mo[k][c], mw[k][c], 29'(mseq[k][c])} : 32'(mcap[k][c]);
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    chk("ack16", 32'(ack16), 32'(m_ack));
    chk("ack8", 32'(ack8), 32'(m_ack));
    chk("irq16", 32'(irq16), 32'(m_irq[0]));
    chk("irq8", 32'(irq8), 32'(m_irq[1]));
    chk("rdata16", rdata16, exp_rd(0));
    chk("rdata8", rdata8, exp_rd(1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic incs(input logic [3:0] m, input int n);
    inc = m;
    repeat (n) step();
    inc = '0;
  endtask
  task automatic sof();
    cap_sof = 1'b1;
    step();
    cap_sof = 1'b0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
    step();
    step();
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
    step();
    d16 = rdata16; d8 = rdata8;
    step();
    wb_cyc = 1'b0;
  endtask
  task automatic rchk(input string name, input logic [7:0] a, input logic [31:0] e16, input logic [31:0] e8);
    rd(a);
    chk({name, "_w16"}, d16, e16);
    chk({name, "_w8"}, d8, e8);
  endtask

  initial begin
    logic [7:0] zero_addrs [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h14, 8'h15};
    n_pass = 0; n_total = 0;
    rst = 1'b1; inc = '0; cap_sof = 0; cap_pps = 0; wb_we = 0; wb_cyc = 0; wb_addr = '0; wb_wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    rchk("rst_en", 8'h00, 0, 0);
    rchk("rst_stat0", 8'h11, 0, 0);
    wr(8'h00, 32'h1);
    rchk("en_rb", 8'h00, 32'h1, 32'h1);
    incs(4'b0001, 1000); sof();
    rchk("d_cap1", 8'h10, 32'd1000, 32'd232);
    rchk("d_stat1", 8'h11, 32'h8000_0001, 32'hA000_0001);
    rchk("d_stat1_clr", 8'h11, 32'h0000_0001, 32'h0000_0001);
    incs(4'b0001, 1000); sof();
    rchk("d_cap2", 8'h10, 32'd1000, 32'd232);
    rchk("d_stat2", 8'h11, 32'h8000_0002, 32'hA000_0002);
    rchk("d_stat2_clr", 8'h11, 32'h0000_0002, 32'h0000_0002);
    incs(4'b0001, 5);
    inc = 4'b0001; cap_sof = 1'b1; step(); inc = '0; cap_sof = 1'b0;
    rchk("cap_with_inc", 8'h10, 32'd5, 32'd5);
    sof();
    rchk("cap_after", 8'h10, 32'd1, 32'd1);
    rchk("overrun", 8'h11, 32'hC000_0004, 32'hC000_0004);
    sof(); sof();
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 8'h11;
    step();
    chk("coinc_rd_w16", rdata16, 32'hC000_0006);
    cap_sof = 1'b1;
    step();
    cap_sof = 1'b0; wb_cyc = 1'b0;
    rchk("coinc_after", 8'h11, 32'h8000_0007, 32'h8000_0007);
    wr(8'h02, 32'h1);
    incs(4'b0001, 100); sof();
    rchk("abs_stat1", 8'h11, 32'h8000_0008, 32'h8000_0008);
    rchk("abs_cap1", 8'h10, 32'd100, 32'd100);
    incs(4'b0001, 200); sof();
    rchk("abs_cap2", 8'h10, 32'd300, 32'd44);
    rchk("abs_stat2", 8'h11, 32'h8000_0009, 32'hA000_0009);
    wr(8'h00, 32'h5); wr(8'h01, 32'h4); wr(8'h03, 32'h4);
    incs(4'b0100, 7);
    cap_pps = 1'b1; step(); cap_pps = 1'b0;
    chk("irq_t1", 32'(irq16), 0);
    step();
    chk("irq_t2_w16", 32'(irq16), 1);
    chk("irq_t2_w8", 32'(irq8), 1);
    sof();
    rchk("pps_cap2", 8'h14, 32'd7, 32'd7);
    rchk("pps_stat2", 8'h15, 32'h8000_0001, 32'h8000_0001);
    step();
    chk("irq_drop", 32'(irq16), 0);
    wr(8'h00, 32'h1);
    incs(4'b0001, 77);
    rst = 1'b1; step(); rst = 1'b0;
    for (int j = 0; j < 8; j++) rchk("post_rst", zero_addrs[j], 0, 0);
    chk("post_rst_irq", 32'(irq16), 0);
    wr(8'h00, 32'h1);
    incs(4'b0001, 3); sof();
    rchk("reen_cap", 8'h10, 32'd3, 32'd3);
    rchk("reen_stat", 8'h11, 32'h8000_0001, 32'h8000_0001);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
